// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU constants, field widths and sequencer state type
package fpu_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;

    localparam int FP_BIAS = 127;

    // An integer with its msb at bit 31 has unbiased exponent 31.
    localparam logic [EXP_W-1:0] I2F_EXP_INIT = EXP_W'(FP_BIAS + 31);

    // Common sequencing states for the multi-cycle FPU blocks.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } fp_seq_state_e;

    // Magnitude of a two's-complement word; the most negative value maps to
    // 0x80000000, which is still correct when read as unsigned.
    function automatic logic [31:0] abs32(input logic [31:0] a);
        return a[31] ? (~a + 32'd1) : a;
    endfunction

endpackage

// File: rtl/int_to_fp_if.sv
// rtl/int_to_fp_if.sv - start/busy/done handshake bundle for the int-to-float converter
interface int_to_fp_if;

    logic        start;
    logic [31:0] A;
    logic        busy;
    logic        done;
    logic [31:0] Result;

    // Requester side: issues the operand and watches for completion.
    modport master (
        output start,
        output A,
        input  busy,
        input  done,
        input  Result
    );

    // Converter side.
    modport slave (
        input  start,
        input  A,
        output busy,
        output done,
        output Result
    );

endinterface

// File: rtl/fp_round_rne.sv
// rtl/fp_round_rne.sv - round-to-nearest-even of a normalised 32-bit significand
module fp_round_rne
    import fpu_pkg::*;
(
    input  logic [31:0]       mag,
    input  logic [EXP_W-1:0]  exp_in,
    output logic [FRAC_W-1:0] frac,
    output logic [EXP_W-1:0]  exp_out
);

    // mag[31] is the hidden one; the next 23 bits are the stored fraction.
    logic [FRAC_W-1:0] frac_trunc;
    logic              guard;
    logic              sticky;
    logic              round_up;
    logic [FRAC_W:0]   frac_sum;

    assign frac_trunc = mag[30:8];
    assign guard      = mag[7];
    assign sticky     = |mag[6:0];

    // Ties (guard set, nothing below) round towards the even fraction.
    assign round_up   = guard & (sticky | frac_trunc[0]);

    assign frac_sum   = {1'b0, frac_trunc} + {{FRAC_W{1'b0}}, round_up};

    // A carry out of the fraction means the significand became 2.0: the
    // fraction wraps to zero and the exponent takes the carry. An input
    // without its leading one is treated as zero.
    always_comb begin
        frac    = '0;
        exp_out = '0;
        if (mag[31]) begin
            frac    = frac_sum[FRAC_W-1:0];
            exp_out = exp_in + {{(EXP_W-1){1'b0}}, frac_sum[FRAC_W]};
        end
    end

endmodule

// File: rtl/int_to_fp.sv
// rtl/int_to_fp.sv - sequential 32-bit signed integer to IEEE-754 single converter
module int_to_fp
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    int_to_fp_if.slave  bus
);

    fp_seq_state_e     state_q;
    fp_seq_state_e     state_d;

    logic              sign_q;
    logic [31:0]       mag_q;
    logic [EXP_W-1:0]  exp_q;
    logic [31:0]       result_q;

    logic              can_accept;
    logic              accept;
    logic [31:0]       a_mag;
    logic              a_is_zero;

    logic [FRAC_W-1:0] rnd_frac;
    logic [EXP_W-1:0]  rnd_exp;

    // New requests are only looked at when no conversion is in flight.
    assign can_accept = (state_q == IDLE) || (state_q == DONE);
    assign accept     = can_accept && bus.start;
    assign a_mag      = abs32(bus.A);
    assign a_is_zero  = (a_mag == 32'd0);

    fp_round_rne u_round (
        .mag     (mag_q),
        .exp_in  (exp_q),
        .frac    (rnd_frac),
        .exp_out (rnd_exp)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: zero skips straight to DONE, everything else normalises
    // one bit per cycle until the leading one reaches bit 31.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = a_is_zero ? DONE : NORM;
                end
            end
            NORM: begin
                if (mag_q[31]) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                state_d = DONE;
            end
            DONE: begin
                if (bus.start) begin
                    state_d = a_is_zero ? DONE : NORM;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: capture operand, shift/decrement while normalising, and
    // register the rounded word; Result holds until the next completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_q   <= 1'b0;
            mag_q    <= 32'd0;
            exp_q    <= '0;
            result_q <= 32'd0;
        end else if (accept) begin
            sign_q <= bus.A[31];
            mag_q  <= a_mag;
            exp_q  <= I2F_EXP_INIT;
            if (a_is_zero) begin
                result_q <= 32'd0;
            end
        end else if ((state_q == NORM) && !mag_q[31]) begin
            mag_q <= {mag_q[30:0], 1'b0};
            exp_q <= exp_q - {{(EXP_W-1){1'b0}}, 1'b1};
        end else if (state_q == ROUND) begin
            result_q <= {sign_q, rnd_exp, rnd_frac};
        end
    end

    // Handshake outputs decode directly from the state.
    assign bus.busy   = (state_q == NORM) || (state_q == ROUND);
    assign bus.done   = (state_q == DONE);
    assign bus.Result = result_q;

endmodule

// File: tb/tb_int_to_fp.sv
// tb/tb_int_to_fp.sv - self-checking bench for int_to_fp
module tb_int_to_fp;

    logic clk = 1'b0;
    logic rst;

    int_to_fp_if bus ();

    int_to_fp dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, expv);
        end
    endtask

    // Position of the most significant one of a nonzero magnitude.
    function automatic int msb_index(input logic [31:0] m);
        int k;
        k = 31;
        while (k > 0 && !m[k]) k--;
        return k;
    endfunction

    // Reference: exact integer arithmetic on the magnitude, rounding the
    // bits beyond 24 significant ones by comparing the remainder to half.
    function automatic logic [31:0] ref_i2f(input logic [31:0] a);
        logic [31:0] m;
        logic [63:0] q, r, half;
        int          k, s;
        logic [7:0]  e;
        if (a == 32'd0) return 32'd0;
        m = a[31] ? (32'd0 - a) : a;
        k = msb_index(m);
        if (k <= 23) begin
            q = 64'(m) << (23 - k);
        end else begin
            s    = k - 23;
            q    = 64'(m) >> s;
            r    = 64'(m) & ((64'd1 << s) - 64'd1);
            half = 64'd1 << (s - 1);
            if (r > half || (r == half && q[0])) q = q + 64'd1;
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                k = k + 1;
            end
        end
        e = 8'(k + 127);
        return {a[31], e, q[22:0]};
    endfunction

    function automatic int ref_latency(input logic [31:0] a);
        logic [31:0] m;
        if (a == 32'd0) return 1;
        m = a[31] ? (32'd0 - a) : a;
        return 34 - msb_index(m);
    endfunction

    // Runs one conversion. Called #1 after an edge; returns #1 after the
    // done edge. Scrambles A while busy, optionally pokes start=1/A=5 at a
    // given busy cycle, and optionally raises start in the done cycle.
    task automatic conv(input logic [31:0] a, input bit drive, input int poke_at,
                        input bit chain, input logic [31:0] chain_a,
                        output logic [31:0] res, output int lat,
                        output bit busy_ok, output bit tmo);
        if (drive) begin
            bus.start = 1'b1;
            bus.A     = a;
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1; busy_ok = 1'b1; tmo = 1'b0;
        while (!bus.done && lat < 40) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (lat == poke_at) begin
                bus.start = 1'b1;
                bus.A     = 32'd5;
            end else begin
                bus.start = 1'b0;
                bus.A     = $urandom;
            end
            @(posedge clk); #1;
            lat++;
        end
        bus.start = 1'b0;
        tmo = (bus.done !== 1'b1);
        if (bus.busy !== 1'b0) busy_ok = 1'b0;
        res = bus.Result;
        if (chain) begin
            bus.start = 1'b1;
            bus.A     = chain_a;
        end
    endtask

    task automatic run_check(input string name, input logic [31:0] a,
                             input logic [31:0] exp_res, input int exp_lat);
        logic [31:0] res;
        int          lat;
        bit          bok, tmo;
        conv(a, 1'b1, -1, 1'b0, 32'd0, res, lat, bok, tmo);
        chk({name, "_timeout"}, 32'(tmo), 32'd0);
        chk({name, "_result"}, res, exp_res);
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({name, "_busy"}, 32'(bok), 32'd1);
    endtask

    initial begin
        logic [31:0] res, held, ra;
        int          lat;
        bit          bok, tmo, seen;

        rst = 1'b1;
        bus.start = 1'b0;
        bus.A = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_result", bus.Result, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        vecs.push_back('{32'h00000003, 32'h40400000, 33});
        vecs.push_back('{32'hFFFFFFF3, 32'hC1500000, 31});
        vecs.push_back('{32'h80000000, 32'hCF000000, 3});
        vecs.push_back('{32'h7FFFFFFF, 32'h4F000000, 4});
        vecs.push_back('{32'h01000001, 32'h4B800000, 10});
        vecs.push_back('{32'h01000003, 32'h4B800002, 10});
        vecs.push_back('{32'h00000000, 32'h00000000, 1});
        vecs.push_back('{32'h00000001, 32'h3F800000, 34});
        vecs.push_back('{32'hFFFFFFFF, 32'hBF800000, 34});
        vecs.push_back('{32'h00FFFFFF, 32'h4B7FFFFF, 11});
        vecs.push_back('{32'h40000000, 32'h4E800000, 4});

        foreach (vecs[i]) begin
            run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].exp_res, vecs[i].exp_lat);
            @(posedge clk); #1;
        end

        // start pulse while busy must be ignored
        conv(32'd3, 1'b1, 5, 1'b0, 32'd0, res, lat, bok, tmo);
        chk("ignore_result", res, 32'h40400000);
        chk("ignore_latency", 32'(lat), 32'd33);
        held = res;
        @(posedge clk); #1;
        chk("hold_done_low", 32'(bus.done), 32'd0);
        chk("hold_result", bus.Result, held);

        // back-to-back: start raised in the done cycle
        conv(32'd3, 1'b1, -1, 1'b1, 32'd5, res, lat, bok, tmo);
        chk("b2b_first", res, 32'h40400000);
        conv(32'd0, 1'b0, -1, 1'b0, 32'd0, res, lat, bok, tmo);
        chk("b2b_timeout", 32'(tmo), 32'd0);
        chk("b2b_second", res, 32'h40A00000);
        chk("b2b_latency", 32'(lat), 32'd32);
        @(posedge clk); #1;

        // reset in the middle of an A=1 conversion
        bus.start = 1'b1;
        bus.A = 32'd1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_result", bus.Result, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            if (bus.done === 1'b1) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("midrst_no_done", 32'(seen), 32'd0);
        run_check("after_rst", 32'd1, 32'h3F800000, 34);
        @(posedge clk); #1;

        // rst and start together: rst wins
        rst = 1'b1;
        bus.start = 1'b1;
        bus.A = 32'd3;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.start = 1'b0;
        chk("rst_start_busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        chk("rst_start_busy2", 32'(bus.busy), 32'd0);
        chk("rst_start_done", 32'(bus.done), 32'd0);

        // randomized operands against the reference model
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0: ra = $urandom;
                1: ra = $urandom >> $urandom_range(0, 31);
                2: ra = 32'd0 - ($urandom >> $urandom_range(0, 31));
                default: ra = ($urandom | 32'h00000080) & ~(32'hFFFFFFFF >> $urandom_range(1, 31)) | 32'(1 << $urandom_range(0, 31));
            endcase
            run_check($sformatf("rnd%0d_%h", n, ra), ra, ref_i2f(ra), ref_latency(ra));
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
